random_range: RTL and testbench

Parametrised pseudo-random source for the jump game: a maximal-length Galois LFSR that advances while `i_roll` is held, plus a request/valid range-reduction engine that returns a uniform-ish value in `[i_min, i_max]`. It replaces the plain roll counter wherever gameplay needs bounded random values, such as platform gap, platform width or bonus placement. Reduction is a bit-serial restoring modulus, so latency is fixed and independent of the operands.

---
 rtl/random_pkg.sv | 14 +
 rtl/random_lfsr.sv | 40 ++++
 rtl/random_range.sv | 156 +++++++++++++++
 tb/tb_random_range.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/random_pkg.sv
// Shared definitions for the bounded random source: FSM state encoding,
// the default 7-bit feedback mask and the value substituted for a zero seed.
package random_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } random_state_e;

  localparam logic [6:0] RANDOM_TAPS_7 = 7'h60;  // x^7 + x^6 + 1
  localparam int RANDOM_ZERO_SEED_SUB = 1;

endpackage

// File: rtl/random_lfsr.sv
// Right-shift Galois LFSR with roll enable and optional seed load.
// A zero seed is replaced so the register can never lock up at 0.
module random_lfsr
  import random_pkg::*;
#(
  parameter int              WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS = WIDTH'(RANDOM_TAPS_7),
  parameter logic [WIDTH-1:0] SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             roll_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] ZERO_SUB  = WIDTH'(RANDOM_ZERO_SEED_SUB);
  localparam logic [WIDTH-1:0] RESET_VAL = (SEED == '0) ? ZERO_SUB : SEED;

  logic [WIDTH-1:0] lfsr_q, lfsr_d;

  // Load wins over roll when both are asserted.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? ZERO_SUB : seed_i;
    end else if (roll_i) begin
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) lfsr_q <= RESET_VAL;
    else      lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/random_range.sv
// Bounded random value engine: snapshots the LFSR and reduces it into [lo, hi]
// with a fixed-latency bit-serial restoring modulus. RANDOM_RANGE_SEED_EN adds seed-load ports.
module random_range
  import random_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(RANDOM_TAPS_7),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
  input  logic             clk_random,
  input  logic             rst_random,
  input  logic             i_roll,
  input  logic             i_req,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_max,
  output logic [WIDTH-1:0] o_random_raw,
  output logic             o_busy,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_value,
  output logic             o_range_err
`ifdef RANDOM_RANGE_SEED_EN
  ,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH - 1);

  logic             seed_load;
  logic [WIDTH-1:0] seed_val;

`ifdef RANDOM_RANGE_SEED_EN
  assign seed_load = i_seed_load;
  assign seed_val  = i_seed;
`else
  assign seed_load = 1'b0;
  assign seed_val  = '0;
`endif

  random_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk     (clk_random),
    .srst    (rst_random),
    .roll_i  (i_roll),
    .load_i  (seed_load),
    .seed_i  (seed_val),
    .state_o (o_random_raw)
  );

  random_state_e state_q, state_d;

  logic [WIDTH-1:0] snap_q, snap_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH:0]   span_q, span_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             range_err_q, range_err_d;

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] span_ext;

  always_ff @(posedge clk_random) begin
    if (rst_random) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_req) state_d = CALC;
      CALC:    if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != IDLE);
  end

  // One restoring step: bring down the next snapshot bit, subtract span if it fits.
  assign trial    = {rem_q, snap_q[WIDTH-1]};
  assign span_ext = {1'b0, span_q};

  always_comb begin
    snap_d      = snap_q;
    lo_d        = lo_q;
    span_d      = span_q;
    rem_d       = rem_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    valid_d     = 1'b0;
    value_d     = value_q;
    range_err_d = range_err_q;
    unique case (state_q)
      IDLE: begin
        if (i_req) begin
          snap_d = o_random_raw;
          lo_d   = i_min;
          span_d = {1'b0, i_max} - {1'b0, i_min} + (WIDTH+1)'(1);
          err_d  = (i_max < i_min);
          rem_d  = '0;
          cnt_d  = CNT_INIT;
        end
      end
      CALC: begin
        rem_d  = (trial >= span_ext) ? (trial - span_ext) : trial;
        snap_d = snap_q << 1;
        cnt_d  = cnt_q - CW'(1);
      end
      DONE: begin
        valid_d     = 1'b1;
        value_d     = err_q ? lo_q : (lo_q + rem_q[WIDTH-1:0]);
        range_err_d = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_random) begin
    if (rst_random) begin
      snap_q      <= '0;
      lo_q        <= '0;
      span_q      <= '0;
      rem_q       <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      value_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      snap_q      <= snap_d;
      lo_q        <= lo_d;
      span_q      <= span_d;
      rem_q       <= rem_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      value_q     <= value_d;
      range_err_q <= range_err_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_value     = value_q;
  assign o_range_err = range_err_q;

endmodule

// File: tb/tb_random_range.sv
// Scoreboard bench for random_range: a cycle-level reference of the LFSR and
// request acceptance pushes expected results; a negedge monitor compares them.
module tb_random_range;

  localparam int W = 7;
  localparam logic [W-1:0] SEED = 7'd1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         roll = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] min_v = '0;
  logic [W-1:0] max_v = '0;
  logic         seed_load = 1'b0;
  logic [W-1:0] seed_v = '0;

  logic [W-1:0] raw;
  logic         busy;
  logic         valid;
  logic [W-1:0] value;
  logic         range_err;

  always #5 clk = ~clk;

  random_range #(
    .WIDTH (W),
    .TAPS  (7'h60),
    .SEED  (SEED)
  ) dut (
    .clk_random   (clk),
    .rst_random   (rst),
    .i_roll       (roll),
    .i_req        (req),
    .i_min        (min_v),
    .i_max        (max_v),
    .o_random_raw (raw),
    .o_busy       (busy),
    .o_valid      (valid),
    .o_value      (value),
    .o_range_err  (range_err)
`ifdef RANDOM_RANGE_SEED_EN
    ,
    .i_seed_load  (seed_load),
    .i_seed       (seed_v)
`endif
  );

  typedef struct {
    int value;
    bit err;
    int due;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   ready_cyc = 0;
  int   acc_cyc = 0;
  bit   have_acc = 1'b0;
  int   model_lfsr = 0;
  int   last_value = 0;
  bit   checking = 1'b0;
  int   valid_count = 0;
  exp_t m_e;
  exp_t mon_e;
  int   m_lo, m_hi;

  function automatic int lfsr_next(int s);
    return (s & 1) ? ((s >> 1) ^ 'h60) : (s >> 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int lo, input int hi);
    min_v = W'(lo);
    max_v = W'(hi);
    req   = 1'b1;
    tick();
    req   = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() > 0 || cyc + 1 < ready_cyc) && n < 40) begin
      tick();
      n++;
    end
    check("drain_timeout", n < 40, 1);
  endtask

  // Reference model: engine accepts a request only once the previous one has
  // fully retired (WIDTH+2 cycles), result appears WIDTH+1 edges after acceptance.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_lfsr = SEED;
      q.delete();
      have_acc   = 1'b0;
      ready_cyc  = cyc + 1;
      last_value = 0;
    end else begin
      if (req && cyc >= ready_cyc) begin
        m_lo = int'(min_v);
        m_hi = int'(max_v);
        if (m_hi < m_lo) begin
          m_e.value = m_lo;
          m_e.err   = 1'b1;
        end else begin
          m_e.value = (m_lo + model_lfsr % (m_hi - m_lo + 1)) % 128;
          m_e.err   = 1'b0;
        end
        m_e.due = cyc + W + 1;
        q.push_back(m_e);
        acc_cyc   = cyc;
        have_acc  = 1'b1;
        ready_cyc = cyc + W + 2;
      end
      if (seed_load)  model_lfsr = (seed_v == 0) ? 1 : int'(seed_v);
      else if (roll)  model_lfsr = lfsr_next(model_lfsr);
    end
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("raw", raw, model_lfsr);
      check("busy", busy, (have_acc && cyc >= acc_cyc && cyc <= acc_cyc + W) ? 1 : 0);
      if (q.size() > 0 && cyc > q[0].due) begin
        checks++;
        failures++;
        $display("FAIL missing_valid: got no o_valid expected one at cyc %0d", q[0].due);
        void'(q.pop_front());
      end
      if (valid) begin
        valid_count++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid: got o_valid=1 expected 0 (cyc %0d)", cyc);
        end else begin
          mon_e = q.pop_front();
          $display("txn cyc=%0d value=%0d err=%0d expected value=%0d err=%0d",
                   cyc, value, range_err, mon_e.value, mon_e.err);
          check("latency", cyc, mon_e.due);
          check("value", value, mon_e.value);
          check("range_err", range_err, mon_e.err);
          last_value = mon_e.value;
        end
      end else begin
        check("hold", value, last_value);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen[128];
    int distinct;
    int zero_hits;
    int vc0;
    int rr;

    rst = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_value", value, 0);
    check("rst_err", range_err, 0);
    check("rst_raw", raw, SEED);
    checking = 1'b1;
    tick();
    rst = 1'b0;

    // Full period walk
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    distinct  = 0;
    zero_hits = 0;
    roll = 1'b1;
    for (int i = 0; i < 127; i++) begin
      tick();
      if (raw == 0) zero_hits++;
      if (!seen[raw]) begin
        seen[raw] = 1'b1;
        distinct++;
      end
    end
    roll = 1'b0;
    check("period_return", raw, 1);
    check("period_distinct", distinct, 127);
    check("period_zero", zero_hits, 0);

    // Bring the LFSR to 100
`ifdef RANDOM_RANGE_SEED_EN
    seed_v    = 7'd100;
    seed_load = 1'b1;
    roll      = 1'b1;
    tick();
    seed_load = 1'b0;
    roll      = 1'b0;
`else
    roll = 1'b1;
    for (int i = 0; i < 130 && model_lfsr != 100; i++) tick();
    roll = 1'b0;
`endif
    check("seek_100", raw, 100);

    do_req(10, 19);
    wait_idle();
    check("dir_10_19", value, 10);
    check("dir_10_19_err", range_err, 0);
    do_req(0, 127);
    wait_idle();
    check("dir_full", value, 100);
    do_req(42, 42);
    wait_idle();
    check("dir_single", value, 42);
    do_req(50, 20);
    wait_idle();
    check("dir_inverted", value, 50);
    check("dir_inverted_err", range_err, 1);

    // Request during CALC is dropped; request at k+9 is taken
    vc0 = valid_count;
    do_req(0, 127);
    tick();
    tick();
    min_v = 7'd5;
    max_v = 7'd6;
    req   = 1'b1;
    tick();
    req   = 1'b0;
    repeat (5) tick();
    do_req(30, 33);
    check("k9_accept_busy", busy, 1);
    wait_idle();
    check("k9_valid_count", valid_count - vc0, 2);
    check("k9_value", value, 30);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      roll = 1'($urandom_range(0, 1));
      req  = ($urandom_range(0, 3) == 0);
      rr   = $urandom_range(0, 9);
      if (rr == 0) begin
        max_v = W'($urandom_range(0, 126));
        min_v = W'($urandom_range(int'(max_v) + 1, 127));
      end else begin
        min_v = W'($urandom_range(0, 127));
        max_v = W'($urandom_range(int'(min_v), 127));
      end
`ifdef RANDOM_RANGE_SEED_EN
      seed_load = ($urandom_range(0, 31) == 0);
      seed_v    = W'($urandom_range(0, 127));
`endif
      tick();
    end
    req       = 1'b0;
    roll      = 1'b0;
    seed_load = 1'b0;
    wait_idle();

    // Reset four cycles into CALC
    roll = 1'b1;
    do_req(3, 90);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst  = 1'b0;
    roll = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_value", value, 0);
    check("mid_rst_raw", raw, SEED);
    repeat (12) tick();

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
